// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Parametrised general-purpose register file with a busy-bit scoreboard.
//   Reads are captured on the rising edge (one-edge latency) with
//   write-to-read bypass. Each register has a busy bit. Issue sets the bit
//   with a reserve, and writeback clears it with a write. Decode reads the
//   busy bit on the same port as the data to detect RAW hazards.
//
// Ports
//   clock          rising-edge system clock
//   reset_n        asynchronous active-low reset
//   write_enable   writeback strobe
//   write_addr     writeback destination register
//   write_data     writeback data
//   read_enable    capture both read ports on this edge
//   read_addr1/2   source register addresses
//   read_data1/2   registered source data
//   read_busy1/2   registered busy flag of each source (post-update value)
//   reserve_enable issue strobe: mark reserve_addr as pending
//   reserve_addr   destination being reserved
//   busy_count     number of busy registers after the last edge
module regfile_scoreboard #(
    parameter int WORD_SIZE  = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [WORD_SIZE-1:0]  write_data,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    output logic [WORD_SIZE-1:0]  read_data1,
    output logic [WORD_SIZE-1:0]  read_data2,
    output logic                  read_busy1,
    output logic                  read_busy2,
    input  logic                  reserve_enable,
    input  logic [ADDR_WIDTH-1:0] reserve_addr,
    output logic [ADDR_WIDTH:0]   busy_count
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    // An address names real storage if it is in range. It must also not be the
    // hardwired zero register.
    function automatic logic is_valid(input logic [ADDR_WIDTH-1:0] addr);
        logic v;
        if (int'(addr) >= NUM_REGS) begin
            v = 1'b0;
        end else if ((ZERO_REG == 1) && (addr == {ADDR_WIDTH{1'b0}})) begin
            v = 1'b0;
        end else begin
            v = 1'b1;
        end
        return v;
    endfunction

    logic [WORD_SIZE-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]  r_busy;
    logic [WORD_SIZE-1:0] r_read_data1;
    logic [WORD_SIZE-1:0] r_read_data2;
    logic                 r_read_busy1;
    logic                 r_read_busy2;
    logic [CNT_W-1:0]     r_busy_count;

    logic                 w_wr_ok;
    logic                 w_rs_ok;
    logic                 w_rd1_ok;
    logic                 w_rd2_ok;
    logic [NUM_REGS-1:0]  w_busy_next;
    logic [CNT_W-1:0]     w_busy_cnt_next;
    logic [WORD_SIZE-1:0] w_rd1_raw;
    logic [WORD_SIZE-1:0] w_rd2_raw;
    logic                 w_rd1_busy_raw;
    logic                 w_rd2_busy_raw;
    logic [WORD_SIZE-1:0] w_rd1_data;
    logic [WORD_SIZE-1:0] w_rd2_data;
    logic                 w_rd1_busy;
    logic                 w_rd2_busy;

    assign w_wr_ok  = write_enable & is_valid(write_addr);
    assign w_rs_ok  = reserve_enable & is_valid(reserve_addr);
    assign w_rd1_ok = is_valid(read_addr1);
    assign w_rd2_ok = is_valid(read_addr2);

    // Next busy vector. The reserve is checked first so a same-address
    // write+reserve leaves the register busy (the new writer wins).
    always_comb begin
        w_busy_next     = r_busy;
        w_busy_cnt_next = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rs_ok && (reserve_addr == ADDR_WIDTH'(i))) begin
                w_busy_next[i] = 1'b1;
            end else if (w_wr_ok && (write_addr == ADDR_WIDTH'(i))) begin
                w_busy_next[i] = 1'b0;
            end else begin
                w_busy_next[i] = r_busy[i];
            end
            w_busy_cnt_next = w_busy_cnt_next + CNT_W'(w_busy_next[i]);
        end
    end

    // Storage and busy-bit lookup for both read ports, using an explicit mux
    // over in-range entries only.
    always_comb begin
        w_rd1_raw      = {WORD_SIZE{1'b0}};
        w_rd2_raw      = {WORD_SIZE{1'b0}};
        w_rd1_busy_raw = 1'b0;
        w_rd2_busy_raw = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_rd1_raw      = (read_addr1 == ADDR_WIDTH'(i)) ? r_regs[i]      : w_rd1_raw;
            w_rd1_busy_raw = (read_addr1 == ADDR_WIDTH'(i)) ? w_busy_next[i] : w_rd1_busy_raw;
            w_rd2_raw      = (read_addr2 == ADDR_WIDTH'(i)) ? r_regs[i]      : w_rd2_raw;
            w_rd2_busy_raw = (read_addr2 == ADDR_WIDTH'(i)) ? w_busy_next[i] : w_rd2_busy_raw;
        end
    end

    // Port 1 result: forced zero for invalid/zero register, bypass on a
    // same-edge write, otherwise stored value.
    always_comb begin
        w_rd1_data = {WORD_SIZE{1'b0}};
        w_rd1_busy = 1'b0;
        if (!w_rd1_ok) begin
            w_rd1_data = {WORD_SIZE{1'b0}};
            w_rd1_busy = 1'b0;
        end else if (write_enable && (write_addr == read_addr1)) begin
            w_rd1_data = write_data;
            w_rd1_busy = w_rd1_busy_raw;
        end else begin
            w_rd1_data = w_rd1_raw;
            w_rd1_busy = w_rd1_busy_raw;
        end
    end

    // Port 2 result, same rules as port 1.
    always_comb begin
        w_rd2_data = {WORD_SIZE{1'b0}};
        w_rd2_busy = 1'b0;
        if (!w_rd2_ok) begin
            w_rd2_data = {WORD_SIZE{1'b0}};
            w_rd2_busy = 1'b0;
        end else if (write_enable && (write_addr == read_addr2)) begin
            w_rd2_data = write_data;
            w_rd2_busy = w_rd2_busy_raw;
        end else begin
            w_rd2_data = w_rd2_raw;
            w_rd2_busy = w_rd2_busy_raw;
        end
    end

    // Register storage: writeback into valid addresses only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {WORD_SIZE{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_ok && (write_addr == ADDR_WIDTH'(i))) begin
                    r_regs[i] <= write_data;
                end else begin
                    r_regs[i] <= r_regs[i];
                end
            end
        end
    end

    // Scoreboard state, busy counter and registered read ports.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy       <= {NUM_REGS{1'b0}};
            r_busy_count <= {CNT_W{1'b0}};
            r_read_data1 <= {WORD_SIZE{1'b0}};
            r_read_data2 <= {WORD_SIZE{1'b0}};
            r_read_busy1 <= 1'b0;
            r_read_busy2 <= 1'b0;
        end else begin
            r_busy       <= w_busy_next;
            r_busy_count <= w_busy_cnt_next;
            if (read_enable) begin
                r_read_data1 <= w_rd1_data;
                r_read_data2 <= w_rd2_data;
                r_read_busy1 <= w_rd1_busy;
                r_read_busy2 <= w_rd2_busy;
            end else begin
                r_read_data1 <= r_read_data1;
                r_read_data2 <= r_read_data2;
                r_read_busy1 <= r_read_busy1;
                r_read_busy2 <= r_read_busy2;
            end
        end
    end

    assign read_data1 = r_read_data1;
    assign read_data2 = r_read_data2;
    assign read_busy1 = r_read_busy1;
    assign read_busy2 = r_read_busy2;
    assign busy_count = r_busy_count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard. Three instances share one input stream:
//   k=0 default (32x32, zero register), k=1 ZERO_REG=0,
//   k=2 WORD_SIZE=16 / NUM_REGS=16 / ADDR_WIDTH=5.
// A reference model uses per-instance arrays and describes the behaviour
// directly. It checks every output after every edge. It also applies
// directed constant checks.
module tb_regfile_scoreboard;

    logic        clock;
    logic        reset_n;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        read_enable;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic        reserve_enable;
    logic [4:0]  reserve_addr;

    logic [31:0] d0_rd1, d0_rd2, d1_rd1, d1_rd2;
    logic [15:0] d2_rd1, d2_rd2;
    logic        d0_b1, d0_b2, d1_b1, d1_b2, d2_b1, d2_b2;
    logic [5:0]  d0_cnt, d1_cnt, d2_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    int          c_nregs [3] = '{32, 32, 16};
    bit          c_zero  [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] c_mask  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
    logic [31:0] m_regs [3][32];
    bit          m_busy [3][32];
    logic [31:0] m_rd1 [3];
    logic [31:0] m_rd2 [3];
    bit          m_b1 [3];
    bit          m_b2 [3];
    int          m_cnt [3];

    regfile_scoreboard u_dut0 (
        .clock(clock), .reset_n(reset_n),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .read_enable(read_enable), .read_addr1(read_addr1), .read_addr2(read_addr2),
        .read_data1(d0_rd1), .read_data2(d0_rd2), .read_busy1(d0_b1), .read_busy2(d0_b2),
        .reserve_enable(reserve_enable), .reserve_addr(reserve_addr), .busy_count(d0_cnt)
    );

    regfile_scoreboard #(.ZERO_REG(0)) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .read_enable(read_enable), .read_addr1(read_addr1), .read_addr2(read_addr2),
        .read_data1(d1_rd1), .read_data2(d1_rd2), .read_busy1(d1_b1), .read_busy2(d1_b2),
        .reserve_enable(reserve_enable), .reserve_addr(reserve_addr), .busy_count(d1_cnt)
    );

    regfile_scoreboard #(.WORD_SIZE(16), .NUM_REGS(16), .ADDR_WIDTH(5), .ZERO_REG(1)) u_dut2 (
        .clock(clock), .reset_n(reset_n),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data[15:0]),
        .read_enable(read_enable), .read_addr1(read_addr1), .read_addr2(read_addr2),
        .read_data1(d2_rd1), .read_data2(d2_rd2), .read_busy1(d2_b1), .read_busy2(d2_b2),
        .reserve_enable(reserve_enable), .reserve_addr(reserve_addr), .busy_count(d2_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit mvalid(input int k, input int a);
        return (a < c_nregs[k]) && !(c_zero[k] && (a == 0));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 32; j++) begin
                m_regs[k][j] = 32'h0;
                m_busy[k][j] = 1'b0;
            end
            m_rd1[k] = 32'h0; m_rd2[k] = 32'h0;
            m_b1[k] = 1'b0;   m_b2[k] = 1'b0;
            m_cnt[k] = 0;
        end
    endtask

    // One clock edge of the architectural behaviour. The write lands first,
    // then the reserve, so a reserve overrides a same-address clear. Reads see
    // the state after this edge, which is where the bypass comes from.
    task automatic model_edge();
        int wa, rsa, a1, a2;
        wa = int'(write_addr); rsa = int'(reserve_addr);
        a1 = int'(read_addr1); a2 = int'(read_addr2);
        for (int k = 0; k < 3; k++) begin
            if (write_enable && mvalid(k, wa)) begin
                m_regs[k][wa] = write_data & c_mask[k];
                m_busy[k][wa] = 1'b0;
            end
            if (reserve_enable && mvalid(k, rsa)) m_busy[k][rsa] = 1'b1;
            if (read_enable) begin
                m_rd1[k] = mvalid(k, a1) ? m_regs[k][a1] : 32'h0;
                m_rd2[k] = mvalid(k, a2) ? m_regs[k][a2] : 32'h0;
                m_b1[k]  = mvalid(k, a1) ? m_busy[k][a1] : 1'b0;
                m_b2[k]  = mvalid(k, a2) ? m_busy[k][a2] : 1'b0;
            end
            m_cnt[k] = 0;
            for (int j = 0; j < 32; j++) m_cnt[k] += int'(m_busy[k][j]);
        end
    endtask

    task automatic check_all(input string where);
        logic [31:0] o_rd1 [3];
        logic [31:0] o_rd2 [3];
        logic        o_b1 [3];
        logic        o_b2 [3];
        logic [5:0]  o_cnt [3];
        o_rd1 = '{d0_rd1, d1_rd1, {16'h0, d2_rd1}};
        o_rd2 = '{d0_rd2, d1_rd2, {16'h0, d2_rd2}};
        o_b1  = '{d0_b1, d1_b1, d2_b1};
        o_b2  = '{d0_b2, d1_b2, d2_b2};
        o_cnt = '{d0_cnt, d1_cnt, d2_cnt};
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s dut%0d read_data1", where, k), 64'(o_rd1[k]), 64'(m_rd1[k]));
            chk($sformatf("%s dut%0d read_data2", where, k), 64'(o_rd2[k]), 64'(m_rd2[k]));
            chk($sformatf("%s dut%0d read_busy1", where, k), 64'(o_b1[k]), 64'(m_b1[k]));
            chk($sformatf("%s dut%0d read_busy2", where, k), 64'(o_b2[k]), 64'(m_b2[k]));
            chk($sformatf("%s dut%0d busy_count", where, k), 64'(o_cnt[k]), 64'(m_cnt[k]));
        end
    endtask

    task automatic step(input string where, input bit we, input int wa, input logic [31:0] wd,
                        input bit ren, input int ra1, input int ra2, input bit rse, input int rsa);
        write_enable   = we;  write_addr   = 5'(wa); write_data = wd;
        read_enable    = ren; read_addr1   = 5'(ra1); read_addr2 = 5'(ra2);
        reserve_enable = rse; reserve_addr = 5'(rsa);
        @(posedge clock);
        model_edge();
        #1;
        check_all(where);
    endtask

    // Reset asserted in the middle of the low clock phase, checked before any edge.
    task automatic do_reset(input string where);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(where);
        chk({where, " rd1 zero"}, 64'(d0_rd1), 64'h0);
        chk({where, " count zero"}, 64'(d0_cnt), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        write_enable = 1'b0; write_addr = 5'd0; write_data = 32'h0;
        read_enable = 1'b0; read_addr1 = 5'd0; read_addr2 = 5'd0;
        reserve_enable = 1'b0; reserve_addr = 5'd0;
        #2;
        reset_n = 1'b0;
        #2;
        model_reset();
        check_all("por");
        @(negedge clock);
        reset_n = 1'b1;

        // x5 written, reserved and read on one edge, then reset mid-cycle.
        step("x5 wr", 1'b1, 5, 32'hDEAD_BEEF, 1'b1, 5, 5, 1'b1, 5);
        chk("x5 bypass", 64'(d0_rd1), 64'hDEAD_BEEF);
        chk("x5 busy", 64'(d0_b1), 64'h1);
        do_reset("midrst");
        step("x5 after rst", 1'b0, 0, 32'h0, 1'b1, 5, 5, 1'b0, 0);
        chk("x5 after rst data", 64'(d0_rd1), 64'h0);

        // Write then read, and same-edge bypass on port 2.
        step("x7 wr", 1'b1, 7, 32'h1234_5678, 1'b0, 0, 0, 1'b0, 0);
        step("x9 byp", 1'b1, 9, 32'hA5A5_A5A5, 1'b1, 7, 9, 1'b0, 0);
        chk("x7 read", 64'(d0_rd1), 64'h1234_5678);
        chk("x9 bypass", 64'(d0_rd2), 64'hA5A5_A5A5);

        // Zero register: write + reserve x0.
        step("x0 wr", 1'b1, 0, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b1, 0);
        step("x0 rd", 1'b0, 0, 32'h0, 1'b1, 0, 0, 1'b0, 0);
        chk("x0 zero data", 64'(d0_rd1), 64'h0);
        chk("x0 zero busy", 64'(d0_b1), 64'h0);
        chk("x0 zero count", 64'(d0_cnt), 64'h0);
        chk("x0 nozero data", 64'(d1_rd1), 64'hFFFF_FFFF);

        // Scoreboard.
        do_reset("sb rst");
        step("rsv3", 1'b0, 0, 32'h0, 1'b0, 0, 0, 1'b1, 3);
        step("rsv4", 1'b0, 0, 32'h0, 1'b1, 3, 4, 1'b1, 4);
        chk("sb count2", 64'(d0_cnt), 64'd2);
        chk("sb x3 busy", 64'(d0_b1), 64'h1);
        step("wr3", 1'b1, 3, 32'h0000_0033, 1'b1, 3, 4, 1'b0, 0);
        chk("sb count1", 64'(d0_cnt), 64'd1);
        chk("sb x3 free", 64'(d0_b1), 64'h0);
        step("rsv4 again", 1'b0, 0, 32'h0, 1'b0, 0, 0, 1'b1, 4);
        chk("sb count stays", 64'(d0_cnt), 64'd1);

        // Collision on x6, then write x6 / reserve x8.
        step("rsv6", 1'b0, 0, 32'h0, 1'b0, 0, 0, 1'b1, 6);
        step("col6", 1'b1, 6, 32'h0000_0055, 1'b0, 0, 0, 1'b1, 6);
        chk("col count", 64'(d0_cnt), 64'd2);
        step("rd6", 1'b0, 0, 32'h0, 1'b1, 6, 6, 1'b0, 0);
        chk("col data", 64'(d0_rd1), 64'h55);
        chk("col busy", 64'(d0_b2), 64'h1);
        step("wr6 rsv8", 1'b1, 6, 32'h0000_0066, 1'b1, 8, 6, 1'b1, 8);
        chk("w6r8 count", 64'(d0_cnt), 64'd2);
        chk("w6r8 x8 busy", 64'(d0_b1), 64'h1);

        // Read hold with read_enable low.
        step("hold", 1'b1, 8, 32'h0000_0088, 1'b0, 1, 1, 1'b0, 0);
        chk("hold busy", 64'(d0_b1), 64'h1);

        // Small configuration: out-of-range write and fill of all 15 registers.
        do_reset("small rst");
        step("x20 wr", 1'b1, 20, 32'h0000_BEEF, 1'b1, 20, 20, 1'b1, 20);
        chk("x20 data", 64'(d2_rd1), 64'h0);
        chk("x20 busy", 64'(d2_b1), 64'h0);
        for (int r = 1; r < 16; r++) step("fill", 1'b0, 0, 32'h0, 1'b0, 0, 0, 1'b1, r);
        chk("small full count", 64'(d2_cnt), 64'd15);

        // Randomized traffic, with one mid-run reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset("rand rst");
            step("rand", ($urandom_range(0, 2) != 0), int'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), ($urandom_range(0, 1) != 0),
                 int'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised general-purpose register file for the RISCV datapath. It replaces the fixed 32x32 file with configurable width, depth and hardwired-zero mode. Reads are synchronous on the rising edge, with write-to-read bypass, so no half-cycle clocking is needed. An integrated busy-bit scoreboard tracks registers with an outstanding writer, so decode can detect RAW hazards without a separate block.

Parameters:
WORD_SIZE, 32, data width in bits
NUM_REGS, 32, number of architectural registers (2..2**ADDR_WIDTH)
ADDR_WIDTH, 5, register address width
ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never busy

Ports:
clock  input  1  system clock, rising-edge active
reset_n  input  1  asynchronous active-low reset
write_enable  input  1  writeback strobe
write_addr  input  ADDR_WIDTH  writeback destination
write_data  input  WORD_SIZE  writeback data
read_enable  input  1  capture read ports this edge
read_addr1  input  ADDR_WIDTH  source 1 address
read_addr2  input  ADDR_WIDTH  source 2 address
read_data1  output  WORD_SIZE  registered source 1 data
read_data2  output  WORD_SIZE  registered source 2 data
read_busy1  output  1  registered: source 1 has pending writer
read_busy2  output  1  registered: source 2 has pending writer
reserve_enable  input  1  issue strobe: mark destination pending
reserve_addr  input  ADDR_WIDTH  destination being reserved
busy_count  output  ADDR_WIDTH+1  number of currently busy registers

Behaviour:
- Reset (reset_n low, asynchronous, any time, including mid-operation): every register is 0, every busy bit is 0, read_data1/2 = 0, read_busy1/2 = 0, busy_count = 0. Reset takes precedence over every other input.
- Valid address: addr < NUM_REGS and not (ZERO_REG=1 and addr=0).
- Write: on a rising edge with write_enable=1 and a valid write_addr, regs[write_addr] <= write_data. Invalid addresses are ignored silently.
- Write clears busy[write_addr] at the same edge, unless a reserve hits the same address at that edge.
- Reserve: on a rising edge with reserve_enable=1 and a valid reserve_addr, busy[reserve_addr] <= 1.
- Simultaneous write and reserve to the same address: the data is written and the busy bit ends at 1 (the new writer wins).
- busy_count equals the number of set busy bits after each edge. It changes by -1, 0 or +1 per edge:
  - reserve of a non-busy register: +1
  - write that clears a busy register: -1
  - both on different addresses: 0
  - reserve of an already-busy register: 0
  - write to a non-busy register: 0
  - same-address write+reserve on a busy register: 0
- Read: latency is one edge. On a rising edge with read_enable=1, each port samples its address:
  - read_dataN <= 0 if the address is invalid or the zero register.
  - Otherwise, read_dataN <= write_data if write_enable=1 and write_addr equals the read address (bypass).
  - Otherwise, read_dataN <= regs[addr].
  - read_busyN <= the busy bit value after this edge's write/reserve updates; 0 for invalid addresses and the zero register.
- read_enable=0: read_data and read_busy outputs hold their previous values. Register writes and reserves still take effect.
- Both ports may address the same register; each gets identical data and busy values.

Test Plan:
- Reset: assert reset_n=0 mid-cycle after writing 0xDEADBEEF to x5 -> outputs 0 immediately. After release, reading x5 returns 0 and busy_count=0.
- Write then read: write 0x12345678 to x7; next edge read_addr1=7 -> read_data1=0x12345678. Same-edge write x9=0xA5A5A5A5 with read_addr2=9 -> read_data2=0xA5A5A5A5 (bypass).
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to x0 and reserve x0 -> read_data1=0, read_busy1=0, busy_count stays 0. With ZERO_REG=0, the same write reads back 0xFFFFFFFF.
- Scoreboard: reserve x3, then x4 -> busy_count=2, read_busy1 for x3 = 1. Write x3 -> busy_count=1, read_busy1 for x3 = 0. Reserve x4 again -> busy_count stays 1.
- Collision: x6 busy; on one edge write x6=0x55 and reserve x6 -> next read returns 0x55, read_busy=1, busy_count unchanged. Write x6 and reserve x8 on one edge -> busy_count unchanged, x8 busy.
- Parametrisation (WORD_SIZE=16, NUM_REGS=16, ADDR_WIDTH=5): write 0xBEEF to x20 -> ignored; reading x20 gives data 0 and busy 0. Reserving all 15 valid registers drives busy_count to 15.
